// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes driven on the ALU control bus and the
// multiply sequencer's state encoding.
package alu_pkg;

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b001;
  localparam logic [2:0] OpNand = 3'b010;
  localparam logic [2:0] OpSlt  = 3'b011;
  localparam logic [2:0] OpShl  = 3'b100;
  localparam logic [2:0] OpShr  = 3'b101;
  localparam logic [2:0] OpBeq  = 3'b110;
  localparam logic [2:0] OpMem  = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StAdd   = 2'b01,
    StShift = 2'b10,
    StDone  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add 8x8 multiplier (low byte) that borrows the shared ALU for
// every add and shift, owning its op code and operands while busy.
import alu_pkg::*;

module alu_mul_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [2:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  seq_state_e state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] m_q, m_d;
  logic [7:0] q_q, q_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= 8'h00;
      m_q       <= 8'h00;
      q_q       <= 8'h00;
      cnt_q     <= 3'd0;
      product_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    alu_op  = OpNop;
    alu_a   = 8'h00;
    alu_b   = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = 8'h00;
          m_d     = a;
          q_d     = b;
          cnt_d   = 3'd0;
          state_d = (b != 8'h00) ? StAdd : StDone;
        end
      end
      StAdd: begin
        if (q_q[0]) begin
          alu_op = OpAdd;
          alu_a  = acc_q;
          alu_b  = m_q;
          acc_d  = alu_result;
        end
        state_d = StShift;
      end
      StShift: begin
        alu_op = OpShl;
        alu_a  = m_q;
        m_d    = alu_result;
        q_d    = q_q >> 1;
        cnt_d  = cnt_q + 3'd1;
        // Stop early once no multiplier bits remain to skip idle iterations.
        state_d = ((cnt_q == 3'd7) || (q_d == 8'h00)) ? StDone : StAdd;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Capture on entry to DONE so the result is already visible while done=1.
    product_d = (state_d == StDone) ? acc_d : product_q;
  end

  assign busy    = (state_q == StAdd) || (state_q == StShift);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized scoreboard bench for alu_mul_seq paired with a behavioural ALU.
module tb_alu_mul_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       busy;
  logic       done;
  logic [7:0] product;

  alu_mul_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  // Behavioural stand-in for the shared single-cycle ALU.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = 8'h00;
      3'b001:  alu_result = alu_a + alu_b;
      3'b010:  alu_result = ~(alu_a & alu_b);
      3'b011:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 8'h01 : 8'h00;
      3'b100:  alu_result = alu_a << 1;
      3'b101:  alu_result = alu_a >> 1;
      3'b110:  alu_result = (alu_a == alu_b) ? 8'h01 : 8'h00;
      default: alu_result = alu_a;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  prod;
    int          k;
    logic [47:0] trace;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: product is plain modular multiplication; the ALU op sequence is
  // one ADD/NOP decision per multiplier bit up to the top set bit, each followed by SHL.
  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input int sc);
    exp_t e;
    int   prod16;
    prod16 = int'(ma) * int'(mb);
    e.prod = prod16[7:0];
    e.k = 0;
    for (int i = 0; i < 8; i++) if (mb[i]) e.k = i + 1;
    e.trace = '0;
    for (int i = 0; i < e.k; i++) begin
      e.trace = {e.trace[44:0], (mb[i] ? 3'b001 : 3'b000)};
      e.trace = {e.trace[44:0], 3'b100};
    end
    e.start_cyc = sc;
    return e;
  endfunction

  // Drive a start for one cycle (or hold it with changing operands for extra cycles).
  task automatic issue(input logic [7:0] op_a, input logic [7:0] op_b, input int hold);
    @(negedge clk);
    start = 1'b1;
    a = op_a;
    b = op_b;
    @(posedge clk);
    #1;
    sb.push_back(model(op_a, op_b, cyc));
    if (hold == 0) start = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      start = (i % 2 == 0);
    end
    if (hold != 0) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0, expected done=1 within 40 cycles");
    end
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_op", {alu_op, alu_a, alu_b}, 0);
  endtask

  task automatic run(input logic [7:0] op_a, input logic [7:0] op_b);
    issue(op_a, op_b, 0);
    @(negedge clk);
    wait_done();
  endtask

  int          busy_cnt = 0;
  logic [47:0] act_trace = '0;
  exp_t        e;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, product, alu_op, alu_a, alu_b}, 0);
    rst_n = 1'b1;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            busy_cnt = 0;
            act_trace = '0;
          end else begin
            if (busy) begin
              busy_cnt++;
              act_trace = {act_trace[44:0], alu_op};
            end
            if (done) begin
              if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no pending result");
              end else begin
                e = sb.pop_front();
                chk("product", product, e.prod);
                chk("latency", cyc - e.start_cyc, 2 * e.k);
                chk("busy_cycles", busy_cnt, 2 * e.k);
                chk("op_trace", act_trace, e.trace);
                chk("done_op", alu_op, 0);
              end
              busy_cnt = 0;
              act_trace = '0;
            end
          end
        end
      end
      begin : driver
        run(8'h03, 8'h05);
        run(8'hFD, 8'h07);
        run(8'h07, 8'hFD);
        run(8'h10, 8'h10);
        run(8'h55, 8'h00);
        run(8'hFF, 8'hFF);
        run(8'h81, 8'h80);

        // Held/re-pulsed start with changing operands must be ignored while busy.
        issue(8'h03, 8'h07, 4);
        wait_done();
        issue(8'h0B, 8'h85, 9);
        wait_done();

        // Reset three edges into a=3,b=5 aborts and clears everything.
        issue(8'h03, 8'h05, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, product, alu_op, alu_a, alu_b}, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(8'h03, 8'h05);

        for (int n = 0; n < 25; n++) begin
          logic [7:0] ra;
          logic [7:0] rb;
          ra = 8'($urandom);
          rb = 8'($urandom) >> $urandom_range(0, 7);
          if (rb != 8'h00 && $urandom_range(0, 2) == 0) begin
            issue(ra, rb, 1);
            wait_done();
          end else begin
            run(ra, rb);
          end
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
      end
    join_any
    disable fork;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
